hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 26 ++
 rtl/scoreboard_entry.sv | 76 +++++++
 rtl/hazard_scoreboard.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard scoreboard:
// control FSM states, exception entry vector and latency counter width.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } hz_state_e;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam int          CNT_W_DEF      = 2;

    // Saturating increment used by the decode-stall counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage request bundle: source operands, destination and producer
// latency of the instruction currently sitting in ID.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = 6,
    parameter int NSRC   = 2,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                     id_valid;
    logic [NSRC*REG_AW-1:0]   id_src;
    logic [NSRC-1:0]          id_src_en;
    logic [REG_AW-1:0]        id_dst;
    logic                     id_dst_we;
    logic [CNT_W-1:0]         id_lat;
    logic                     id_long;

    modport master (
        output id_valid, id_src, id_src_en, id_dst, id_dst_we, id_lat, id_long
    );

    modport slave (
        input  id_valid, id_src, id_src_en, id_dst, id_dst_we, id_lat, id_long
    );

endinterface

// File: rtl/scoreboard_entry.sv
// One tracked register: busy flag, unbounded-latency (divide) flag and the
// countdown until its result becomes forwardable.
module scoreboard_entry
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             issue,
    input  logic             issue_long,
    input  logic [CNT_W-1:0] issue_lat,
    input  logic             div_done,
    input  logic             clear,
    output logic             busy,
    output logic             long_pend
);

    logic             busy_r;
    logic             long_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_nx_s;
    logic             long_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;

    // Next entry state: a new producer beats any clear, a clear beats the countdown.
    always_comb begin
        busy_nx_s = busy_r;
        long_nx_s = long_r;
        cnt_nx_s  = cnt_r;
        if (issue && (issue_long || (issue_lat != {CNT_W{1'b0}}))) begin
            busy_nx_s = 1'b1;
            long_nx_s = issue_long;
            cnt_nx_s  = issue_long ? {CNT_W{1'b0}} : issue_lat;
        end else if (clear) begin
            busy_nx_s = 1'b0;
            long_nx_s = 1'b0;
            cnt_nx_s  = {CNT_W{1'b0}};
        end else if (long_r) begin
            // Divide completion is reported even while the pipe is frozen.
            if (div_done) begin
                busy_nx_s = 1'b0;
                long_nx_s = 1'b0;
            end else begin
                busy_nx_s = busy_r;
            end
        end else if (busy_r && !freeze) begin
            if (cnt_r == CNT_W'(1)) begin
                busy_nx_s = 1'b0;
                cnt_nx_s  = {CNT_W{1'b0}};
            end else begin
                cnt_nx_s  = cnt_r - CNT_W'(1);
            end
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Entry state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            long_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            busy_r <= busy_nx_s;
            long_r <= long_nx_s;
            cnt_r  <= cnt_nx_s;
        end
    end

    assign busy      = busy_r;
    assign long_pend = long_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: per-register result scoreboard driving decode stalls,
// plus the exception/ERET drain-and-redirect sequencer.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int          NREG       = 34,
    parameter int          REG_AW     = 6,
    parameter int          NSRC       = 2,
    parameter int          CNT_W      = CNT_W_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  dec,
    input  logic                fetch_stall,
    input  logic                mem_stall,
    input  logic                div_done,
    input  logic                exc_req,
    input  logic                exc_eret,
    input  logic [31:0]         epc,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                stall_m,
    output logic                stall_w,
    output logic                flush_f,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_m,
    output logic                flush_w,
    output logic                pc_redirect,
    output logic [31:0]         new_pc,
    output logic [NREG-1:0]     busy_vec,
    output logic [31:0]         stall_cnt
);

    localparam int NIDX = 1 << REG_AW;

    hz_state_e          state_r;
    hz_state_e          state_nx_s;
    logic               latch_pc_s;
    logic [31:0]        new_pc_r;
    logic [31:0]        stall_cnt_r;
    logic [NREG-1:0]    busy_s;
    logic [NREG-1:0]    long_s;
    logic [NIDX-1:0]    busy_ext_s;
    logic               freeze_s;
    logic               raw_s;
    logic               div_s;
    logic               front_s;
    logic               back_s;
    logic               redir_s;
    logic               hazard_flush_s;
    logic               issue_s;
    logic               clear_s;

    assign freeze_s = fetch_stall | mem_stall;

    // Zero-pad busy flags so any source index can be looked up directly.
    always_comb begin
        busy_ext_s             = {NIDX{1'b0}};
        busy_ext_s[NREG-1:0]   = busy_s;
    end

    // Read-after-write hazard on any enabled, non-zero source operand.
    always_comb begin
        raw_s = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            raw_s = raw_s
                  | (dec.id_src_en[s]
                     & (dec.id_src[s*REG_AW +: REG_AW] != {REG_AW{1'b0}})
                     & busy_ext_s[dec.id_src[s*REG_AW +: REG_AW]]);
        end
        raw_s = raw_s & dec.id_valid;
    end

    assign div_s   = dec.id_valid & dec.id_long & (|long_s);
    assign front_s = raw_s | div_s | freeze_s | (state_r != IDLE);
    assign back_s  = freeze_s | (state_r == DRAIN);
    assign redir_s = (state_r == REDIRECT);
    assign hazard_flush_s = (raw_s | div_s) & ~freeze_s & (state_r == IDLE);

    assign issue_s = dec.id_valid & ~front_s & ~exc_req & dec.id_dst_we
                   & (dec.id_dst != {REG_AW{1'b0}});

    // Entries are wiped on the edge into REDIRECT so busy_vec is clean while redirecting.
    assign clear_s = (state_nx_s == REDIRECT);

    // Outputs are held quiet while reset is asserted.
    assign stall_f     = front_s & ~rst;
    assign stall_d     = front_s & ~rst;
    assign stall_e     = back_s & ~rst;
    assign stall_m     = back_s & ~rst;
    assign stall_w     = back_s & ~rst;
    assign flush_f     = redir_s & ~rst;
    assign flush_d     = redir_s & ~rst;
    assign flush_e     = (hazard_flush_s | redir_s) & ~rst;
    assign flush_m     = redir_s & ~rst;
    assign flush_w     = redir_s & ~rst;
    assign pc_redirect = redir_s & ~rst;

    assign busy_s[0] = 1'b0;
    assign long_s[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        scoreboard_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .freeze     (freeze_s),
            .issue      (issue_s & (dec.id_dst == REG_AW'(i))),
            .issue_long (dec.id_long),
            .issue_lat  (dec.id_lat),
            .div_done   (div_done),
            .clear      (clear_s),
            .busy       (busy_s[i]),
            .long_pend  (long_s[i])
        );
    end

    assign busy_vec = busy_s;

    // Exception sequencer next state; requests outside IDLE are dropped.
    always_comb begin
        state_nx_s = state_r;
        latch_pc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (exc_req) begin
                    latch_pc_s = 1'b1;
                    state_nx_s = freeze_s ? DRAIN : REDIRECT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DRAIN: begin
                if (!freeze_s) begin
                    state_nx_s = REDIRECT;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            REDIRECT: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Redirect target captured when the request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            new_pc_r <= EXC_VECTOR;
        end else if (latch_pc_s) begin
            new_pc_r <= exc_eret ? epc : EXC_VECTOR;
        end
    end

    // Saturating count of cycles spent with decode stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_d) begin
            stall_cnt_r <= sat_inc32(stall_cnt_r);
        end
    end

    assign new_pc    = new_pc_r;
    assign stall_cnt = stall_cnt_r;

endmodule
